// File: rtl/bip_run_ctrl.sv
// Run/step/halt controller for the BIP core, driven by host command bytes.
// Ports: i_clk/i_rst, i_cmd/i_cmd_valid/o_cmd_ready command link,
//  i_instruction/i_acc core taps, o_cpu_en/o_cpu_rst core control,
//  o_tx_data/o_tx_valid/i_tx_ready dump stream, o_state, o_bad_cmd.
module bip_run_ctrl #(
  parameter int DATA_WIDTH = 16,
  parameter int NB_SIGX    = 11,
  parameter int RST_CYCLES = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [7:0]            i_cmd,
  input  logic                  i_cmd_valid,
  output logic                  o_cmd_ready,
  input  logic [DATA_WIDTH-1:0] i_instruction,
  input  logic [DATA_WIDTH-1:0] i_acc,
  output logic                  o_cpu_en,
  output logic                  o_cpu_rst,
  output logic [7:0]            o_tx_data,
  output logic                  o_tx_valid,
  input  logic                  i_tx_ready,
  output logic [2:0]            o_state,
  output logic                  o_bad_cmd
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RUN  = 3'd1,
    STEP = 3'd2,
    HALT = 3'd3,
    DUMP = 3'd4,
    CRST = 3'd5
  } state_t;

  localparam logic [7:0] CMD_RUN   = 8'h72;
  localparam logic [7:0] CMD_STEP  = 8'h73;
  localparam logic [7:0] CMD_PAUSE = 8'h70;
  localparam logic [7:0] CMD_DUMP  = 8'h64;
  localparam logic [7:0] CMD_CRST  = 8'h63;

  localparam int RW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [RW-1:0] RST_LAST = RW'(RST_CYCLES - 1);

  state_t                state;
  state_t                nxt;
  logic [RW-1:0]         rst_cnt;
  logic [15:0]           cyc;
  logic [DATA_WIDTH-1:0] snap;
  logic [1:0]            idx;
  logic                  ret_halt;
  logic                  accept;
  logic                  known;
  logic                  hlt;
  logic                  hs;
  logic [7:0]            nbyte;
  logic                  unused;

  assign accept = i_cmd_valid & o_cmd_ready;
  assign known  = (i_cmd == CMD_RUN) || (i_cmd == CMD_STEP) ||
                  (i_cmd == CMD_PAUSE) || (i_cmd == CMD_DUMP) ||
                  (i_cmd == CMD_CRST);
  assign hlt    = o_cpu_en &&
                  (i_instruction[DATA_WIDTH-1:NB_SIGX] == '0);
  assign hs     = o_tx_valid & i_tx_ready;
  assign o_state = state;
  assign unused  = ^i_instruction[NB_SIGX-1:0];

  // byte that follows the one currently on o_tx_data
  always_comb begin
    nbyte = 8'h00;
    unique case (idx)
      2'd0: nbyte = cyc[7:0];
      2'd1: nbyte = snap[15:8];
      2'd2: nbyte = snap[7:0];
      default: nbyte = 8'h00;
    endcase
  end

  always_comb begin
    nxt = state;
    unique case (state)
      CRST: if (rst_cnt == RST_LAST) nxt = IDLE;
      IDLE: if (accept) begin
        if (i_cmd == CMD_RUN) nxt = RUN;
        else if (i_cmd == CMD_STEP) nxt = STEP;
        else if (i_cmd == CMD_DUMP) nxt = DUMP;
        else if (i_cmd == CMD_CRST) nxt = CRST;
      end
      // halt beats a pause arriving in the same cycle
      RUN: if (hlt) nxt = HALT;
        else if (accept && i_cmd == CMD_PAUSE) nxt = IDLE;
      STEP: nxt = hlt ? HALT : IDLE;
      HALT: if (accept) begin
        if (i_cmd == CMD_DUMP) nxt = DUMP;
        else if (i_cmd == CMD_CRST) nxt = CRST;
      end
      DUMP: if (hs && idx == 2'd3) nxt = ret_halt ? HALT : IDLE;
      default: nxt = CRST;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state <= CRST;
    else state <= nxt;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_cpu_rst   <= 1'b1;
      o_cpu_en    <= 1'b0;
      o_cmd_ready <= 1'b0;
      o_bad_cmd   <= 1'b0;
      o_tx_valid  <= 1'b0;
      o_tx_data   <= 8'h00;
      rst_cnt     <= '0;
      cyc         <= 16'h0000;
      snap        <= '0;
      idx         <= 2'd0;
      ret_halt    <= 1'b0;
    end else begin
      o_cpu_rst   <= (nxt == CRST);
      o_cpu_en    <= (nxt == RUN) || (nxt == STEP);
      o_cmd_ready <= (nxt == IDLE) || (nxt == RUN) || (nxt == HALT);
      o_bad_cmd   <= accept && !known;
      if (state == CRST && nxt == CRST) rst_cnt <= rst_cnt + 1'b1;
      else rst_cnt <= '0;
      if (state != CRST && nxt == CRST) begin
        cyc  <= 16'h0000;
        snap <= '0;
      end else begin
        if (o_cpu_en && cyc != 16'hFFFF) cyc <= cyc + 16'd1;
        if (hlt || (state == IDLE && nxt == DUMP)) snap <= i_acc;
      end
      if (state != DUMP && nxt == DUMP) begin
        ret_halt   <= (state == HALT);
        idx        <= 2'd0;
        o_tx_valid <= 1'b1;
        o_tx_data  <= cyc[15:8];
      end else if (hs) begin
        idx <= idx + 2'd1;
        if (idx == 2'd3) begin
          o_tx_valid <= 1'b0;
          o_tx_data  <= 8'h00;
        end else begin
          o_tx_data <= nbyte;
        end
      end
    end
  end

endmodule

// File: tb/tb_bip_run_ctrl.sv
// Self-checking bench for bip_run_ctrl: vector table, directed
// multi-cycle sequences and randomized ops against a counting model.
module tb_bip_run_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  cmd = 8'h00;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [15:0] instr = 16'h0800;
  logic [15:0] acc = 16'h0000;
  logic        cpu_en;
  logic        cpu_rst;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b0;
  logic [2:0]  state;
  logic        bad_cmd;

  int checks = 0;
  int failures = 0;
  int en_cycles = 0;
  int en_pulses = 0;
  logic en_prev = 1'b0;

  localparam logic [7:0] C_R = 8'h72;
  localparam logic [7:0] C_S = 8'h73;
  localparam logic [7:0] C_P = 8'h70;
  localparam logic [7:0] C_D = 8'h64;
  localparam logic [7:0] C_C = 8'h63;
  localparam logic [15:0] NZ = 16'h0800;

  bip_run_ctrl dut (
    .i_clk(clk), .i_rst(rst), .i_cmd(cmd), .i_cmd_valid(cmd_valid),
    .o_cmd_ready(cmd_ready), .i_instruction(instr), .i_acc(acc),
    .o_cpu_en(cpu_en), .o_cpu_rst(cpu_rst), .o_tx_data(tx_data),
    .o_tx_valid(tx_valid), .i_tx_ready(tx_ready), .o_state(state),
    .o_bad_cmd(bad_cmd)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (cpu_en) en_cycles++;
    if (cpu_en && !en_prev) en_pulses++;
    en_prev = cpu_en;
  end

  typedef struct {
    logic       hlt;
    logic [7:0] c;
    logic [2:0] st;
    logic       bad;
    logic       en;
    logic       rdy;
  } vec_t;

  vec_t vecs[15];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic timeout(input string nm);
    checks++;
    failures++;
    $display("FAIL %s timeout", nm);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    int n;
    n = 0;
    while (!cmd_ready && n < 200) begin
      tick();
      n++;
    end
    if (!cmd_ready) timeout("send_ready");
    cmd = b;
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(input string nm);
    int n;
    n = 0;
    while (state != 3'd0 && n < 50) begin
      tick();
      n++;
    end
    if (state != 3'd0) timeout(nm);
  endtask

  function automatic int sat(input int v);
    return (v > 65535) ? 65535 : v;
  endfunction

  // mode 0: ready held, 1: ready toggles 1/0, 2: random ready
  task automatic dump(input logic [31:0] exp, input int mode,
                      input string nm);
    logic [7:0] got[4];
    logic [7:0] held;
    logic stalled;
    int n;
    int c;
    n = 0;
    c = 0;
    stalled = 1'b0;
    held = 8'h00;
    send(C_D);
    chk({nm, "_valid_first"}, 32'(tx_valid), 32'd1);
    while (n < 4 && c < 200) begin
      if (mode == 0) tx_ready = 1'b1;
      else if (mode == 1) tx_ready = ~c[0];
      else tx_ready = 1'($urandom);
      if (stalled) chk({nm, "_stable"}, 32'(tx_data), 32'(held));
      stalled = 1'b0;
      if (tx_valid) begin
        if (tx_ready) begin
          got[n] = tx_data;
          n++;
        end else begin
          stalled = 1'b1;
          held = tx_data;
        end
      end
      tick();
      c++;
    end
    tx_ready = 1'b0;
    chk({nm, "_handshakes"}, 32'(n), 32'd4);
    if (n == 4)
      chk({nm, "_bytes"}, {got[0], got[1], got[2], got[3]}, exp);
    chk({nm, "_valid_end"}, 32'(tx_valid), 32'd0);
  endtask

  task automatic release_check(input string nm);
    int n;
    n = 0;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (cpu_rst) n++;
      else break;
    end
    chk({nm, "_rst_len"}, 32'(n), 32'd4);
    chk({nm, "_state"}, 32'(state), 32'd0);
    chk({nm, "_ready"}, 32'(cmd_ready), 32'd1);
    chk({nm, "_en"}, 32'(cpu_en), 32'd0);
    tick();
  endtask

  int m_cnt;
  logic [15:0] m_snap;
  int op;
  int k;
  int base;
  int pbase;
  logic [7:0] b;

  initial begin
    vecs[0]  = '{1'b0, 8'h55, 3'd0, 1'b1, 1'b0, 1'b1};
    vecs[1]  = '{1'b0, C_P,   3'd0, 1'b0, 1'b0, 1'b1};
    vecs[2]  = '{1'b0, C_S,   3'd2, 1'b0, 1'b1, 1'b0};
    vecs[3]  = '{1'b0, C_R,   3'd1, 1'b0, 1'b1, 1'b1};
    vecs[4]  = '{1'b0, C_R,   3'd1, 1'b0, 1'b1, 1'b1};
    vecs[5]  = '{1'b0, C_S,   3'd1, 1'b0, 1'b1, 1'b1};
    vecs[6]  = '{1'b0, C_D,   3'd1, 1'b0, 1'b1, 1'b1};
    vecs[7]  = '{1'b0, C_C,   3'd1, 1'b0, 1'b1, 1'b1};
    vecs[8]  = '{1'b0, 8'hAA, 3'd1, 1'b1, 1'b1, 1'b1};
    vecs[9]  = '{1'b1, 8'h00, 3'd3, 1'b0, 1'b0, 1'b1};
    vecs[10] = '{1'b0, C_R,   3'd3, 1'b0, 1'b0, 1'b1};
    vecs[11] = '{1'b0, C_S,   3'd3, 1'b0, 1'b0, 1'b1};
    vecs[12] = '{1'b0, C_P,   3'd3, 1'b0, 1'b0, 1'b1};
    vecs[13] = '{1'b0, 8'h00, 3'd3, 1'b1, 1'b0, 1'b1};
    vecs[14] = '{1'b0, C_C,   3'd5, 1'b0, 1'b0, 1'b0};

    // reset values and release
    tick();
    tick();
    chk("rst_state", 32'(state), 32'd5);
    chk("rst_cpu_rst", 32'(cpu_rst), 32'd1);
    chk("rst_outs", {cpu_en, tx_valid, cmd_ready, bad_cmd}, 32'd0);
    chk("rst_txdata", 32'(tx_data), 32'd0);
    release_check("release");

    // command table
    for (int i = 0; i < 15; i++) begin
      if (vecs[i].hlt) begin
        instr = 16'h0000;
        tick();
        instr = NZ;
      end else begin
        send(vecs[i].c);
      end
      chk($sformatf("vec%0d_state", i), 32'(state), 32'(vecs[i].st));
      chk($sformatf("vec%0d_bad", i), 32'(bad_cmd), 32'(vecs[i].bad));
      chk($sformatf("vec%0d_en", i), 32'(cpu_en), 32'(vecs[i].en));
      chk($sformatf("vec%0d_rdy", i), 32'(cmd_ready), 32'(vecs[i].rdy));
    end
    wait_idle("vec_idle");

    // run until HLT on 6th enabled cycle
    send(C_C);
    wait_idle("t2_idle");
    acc = 16'h0042;
    base = en_cycles;
    send(C_R);
    repeat (5) tick();
    instr = 16'h0000;
    tick();
    instr = NZ;
    chk("t2_state", 32'(state), 32'd3);
    chk("t2_en", 32'(cpu_en), 32'd0);
    tick();
    chk("t2_en_cycles", 32'(en_cycles - base), 32'd6);
    acc = 16'h7777;
    dump(32'h0006_0042, 0, "t2_dump");
    chk("t2_back_halt", 32'(state), 32'd3);

    // three single steps
    send(C_C);
    wait_idle("t3_idle");
    base = en_cycles;
    pbase = en_pulses;
    repeat (3) send(C_S);
    repeat (3) tick();
    chk("t3_en_cycles", 32'(en_cycles - base), 32'd3);
    chk("t3_pulses", 32'(en_pulses - pbase), 32'd3);
    acc = 16'h1111;
    dump(32'h0003_1111, 0, "t3_dump");

    // counter 0x0102, stalled dump
    send(C_C);
    wait_idle("t4_idle");
    send(C_R);
    repeat (257) tick();
    send(C_P);
    acc = 16'hBEEF;
    dump(32'h0102_BEEF, 1, "t4_dump");
    chk("t4_back_idle", 32'(state), 32'd0);

    // unknown byte in RUN, pause, pause with HLT
    send(C_C);
    wait_idle("t5_idle");
    send(C_R);
    send(8'h55);
    chk("t5_bad", 32'(bad_cmd), 32'd1);
    chk("t5_run_kept", 32'(state), 32'd1);
    send(C_P);
    chk("t5_bad_1cyc", 32'(bad_cmd), 32'd0);
    chk("t5_pause", 32'(state), 32'd0);
    repeat (5) tick();
    acc = 16'h0A0B;
    dump(32'h0002_0A0B, 0, "t5_frozen");
    acc = 16'hC0DE;
    send(C_R);
    instr = 16'h0000;
    cmd = C_P;
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    instr = NZ;
    chk("t5_hlt_wins", 32'(state), 32'd3);
    acc = 16'h0000;
    dump(32'h0003_C0DE, 2, "t5_halt_dump");
    send(C_C);
    wait_idle("t5_end");

    // randomized ops against a counting model
    m_cnt = 0;
    m_snap = 16'h0000;
    for (int it = 0; it < 40; it++) begin
      op = $urandom_range(0, 5);
      acc = 16'($urandom);
      case (op)
        0: begin
          k = $urandom_range(0, 20);
          send(C_R);
          repeat (k) tick();
          send(C_P);
          m_cnt = sat(m_cnt + k + 1);
          chk("rnd_pause", 32'(state), 32'd0);
        end
        1: begin
          send(C_S);
          tick();
          m_cnt = sat(m_cnt + 1);
          chk("rnd_step", 32'(state), 32'd0);
        end
        2: begin
          b = 8'($urandom);
          while (b == C_R || b == C_S || b == C_P || b == C_D || b == C_C)
            b = 8'($urandom);
          send(b);
          chk("rnd_bad", 32'(bad_cmd), 32'd1);
          chk("rnd_bad_state", 32'(state), 32'd0);
        end
        3: begin
          dump({16'(m_cnt), acc}, 2, "rnd_idle_dump");
          chk("rnd_dump_idle", 32'(state), 32'd0);
        end
        4: begin
          k = $urandom_range(1, 12);
          send(C_R);
          repeat (k - 1) tick();
          instr = 16'h0000;
          tick();
          instr = NZ;
          m_cnt = sat(m_cnt + k);
          m_snap = acc;
          chk("rnd_halt", 32'(state), 32'd3);
          acc = 16'($urandom);
          dump({16'(m_cnt), m_snap}, 2, "rnd_halt_dump");
          chk("rnd_dump_halt", 32'(state), 32'd3);
          send(C_C);
          m_cnt = 0;
          wait_idle("rnd_crst");
        end
        default: begin
          send(C_C);
          m_cnt = 0;
          wait_idle("rnd_crst2");
        end
      endcase
    end

    // counter saturation
    send(C_R);
    repeat (65540) tick();
    send(C_P);
    m_cnt = sat(m_cnt + 65541);
    acc = 16'h5A5A;
    dump({16'(m_cnt), 16'h5A5A}, 0, "sat_dump");

    // async reset in the middle of a dump
    acc = 16'h9876;
    send(C_D);
    tx_ready = 1'b1;
    tick();
    tick();
    chk("t6_third_byte", 32'(tx_data), 32'h98);
    #2;
    rst = 1'b1;
    #1;
    tx_ready = 1'b0;
    chk("t6_valid_drop", 32'(tx_valid), 32'd0);
    chk("t6_state", 32'(state), 32'd5);
    chk("t6_cpu_rst", 32'(cpu_rst), 32'd1);
    release_check("t6_release");
    acc = 16'h1234;
    dump(32'h0000_1234, 0, "t6_cnt_cleared");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
